fetch_queue: RTL and testbench

- Instruction fetch buffer between the instruction ROM (fetch stage) and the decode stage.
- Captures each {pc, instruction} pair produced by fetch into a small circular FIFO.
- Presents the oldest pair to decode through a valid/ready handshake.
- Back-pressures the PC loader through push_ready, and discards all buffered entries on a branch/jump flush.

---
 rtl/fetch_queue_pkg.sv | 8 +
 rtl/fetch_queue.sv | 62 ++++++
 tb/tb_fetch_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: default geometry and the NOP issued to decode when empty.
package fetch_queue_pkg;
  localparam int FQ_ADDR_W = 6;   // MemAddr range
  localparam int FQ_DATA_W = 32;  // DataSize range
  localparam int FQ_DEPTH  = 4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/fetch_queue.sv
// Circular {pc, inst} FIFO between fetch and decode; no bypass, flush drops all entries.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int DATA_W = FQ_DATA_W,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic [DATA_W-1:0]          push_inst,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [ADDR_W-1:0]          pop_pc,
  output logic [DATA_W-1:0]          pop_inst,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_pc;
  logic [DEPTH-1:0][DATA_W-1:0] mem_inst;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  // Ready depends only on registered occupancy: no decode-to-fetch comb path.
  assign push_ready = (count != CNT_W'(DEPTH));
  assign pop_valid  = (count != '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  assign pop_pc   = pop_valid ? mem_pc[rd_ptr]   : '0;
  assign pop_inst = pop_valid ? mem_inst[rd_ptr] : DATA_W'(NOP_INST);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are never visible while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus enqueues expected pops, a negedge monitor scores them.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset, flush, push_valid, pop_ready;
  logic [5:0]  push_pc;
  logic [31:0] push_inst;
  logic        push_ready, pop_valid;
  logic [5:0]  pop_pc;
  logic [31:0] pop_inst;
  logic [2:0]  count;

  typedef struct packed {
    logic [5:0]  pc;
    logic [31:0] inst;
  } entry_t;

  entry_t exp_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_inst(push_inst), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_inst(pop_inst), .pop_ready(pop_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] pc, input logic [31:0] inst, input bit accepted);
    push_valid = 1'b1;
    push_pc    = pc;
    push_inst  = inst;
    if (accepted) exp_q.push_back('{pc: pc, inst: inst});
  endtask

  // Monitor: each pop handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && !flush && pop_valid && pop_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got pc %0d, expected no pop", pop_pc);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("pop_pc", 32'(pop_pc), 32'(e.pc));
        chk("pop_inst", pop_inst, e.inst);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_pc = '0; push_inst = '0;

    // Reset then idle
    step(); step();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_pop_pc", 32'(pop_pc), 0);
    chk("rst_pop_inst", pop_inst, 32'h0000_0013);
    chk("rst_push_ready", 32'(push_ready), 1);
    step();
    chk("idle_count", 32'(count), 0);

    // Fill to full
    for (int i = 1; i <= 4; i++) begin
      push(6'(i), 32'hA0 + 32'(i), 1'b1);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_push_ready", 32'(push_ready), (i == 4) ? 32'd0 : 32'd1);
    end
    push(6'd5, 32'hA5, 1'b0);
    step();
    push_valid = 1'b0;
    chk("full_count", 32'(count), 4);
    chk("full_head_pc", 32'(pop_pc), 1);
    chk("full_head_inst", pop_inst, 32'hA1);

    // Drain in order
    pop_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_count", 32'(count), 32'(4 - i));
    end
    pop_ready = 1'b0;
    chk("drain_pop_valid", 32'(pop_valid), 0);
    chk("drain_pop_inst", pop_inst, 32'h0000_0013);

    // Streaming across pointer wrap, occupancy held at 1
    push(6'd0, 32'hB0, 1'b1);
    step();
    pop_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push(6'(i), 32'hB0 + 32'(i), 1'b1);
      step();
      chk("stream_count", 32'(count), 1);
    end
    push_valid = 1'b0;
    step();
    pop_ready = 1'b0;
    chk("stream_empty", 32'(count), 0);

    // Full with simultaneous push and pop: only the pop happens
    for (int i = 0; i < 4; i++) begin
      push(6'(20 + i), 32'hC0 + 32'(i), 1'b1);
      step();
    end
    chk("full2_count", 32'(count), 4);
    push(6'd24, 32'hC4, 1'b0);
    pop_ready = 1'b1;
    step();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    chk("fullpp_count", 32'(count), 3);
    chk("fullpp_push_ready", 32'(push_ready), 1);

    // Flush with a concurrent push: nothing stored
    flush = 1'b1;
    push(6'd9, 32'h99, 1'b0);
    pop_ready = 1'b1;
    step();
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_pop_valid", 32'(pop_valid), 0);
    chk("flush_push_ready", 32'(push_ready), 1);

    // Refill, check head is the first post-flush push
    push(6'd30, 32'hD0, 1'b1); step();
    push(6'd31, 32'hD1, 1'b1); step();
    push_valid = 1'b0;
    chk("refill_count", 32'(count), 2);
    chk("refill_head", 32'(pop_pc), 30);

    // Reset and flush together mid-operation
    reset = 1'b1; flush = 1'b1;
    push(6'd40, 32'hE0, 1'b0);
    step();
    reset = 1'b0; flush = 1'b0; push_valid = 1'b0;
    exp_q.delete();
    chk("rst2_count", 32'(count), 0);
    chk("rst2_push_ready", 32'(push_ready), 1);
    chk("rst2_pop_valid", 32'(pop_valid), 0);
    chk("rst2_pop_pc", 32'(pop_pc), 0);
    chk("rst2_pop_inst", pop_inst, 32'h0000_0013);

    // Normal operation resumes after reset
    push(6'd50, 32'hF0, 1'b1);
    step();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    step();
    pop_ready = 1'b0;
    chk("post_count", 32'(count), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
